reg_snapshot_ctrl: RTL and testbench

Checkpoint controller for the register file's snapshot/recover port.
- Captures the live architectural registers into a circular buffer of slots when a branch issues.
- Retires slots in order as branches resolve correct.
- On a mispredict, drives recover_snapshot and regs_snapshot into reg_file, waits for its done flag, then pulses recovery_done_ack.
- Sits between decode/branch-resolve logic and reg_file.

---
 rtl/mips_core_pkg.sv | 17 +
 rtl/reg_snapshot_ctrl_if.sv | 23 ++
 rtl/snapshot_store.sv | 45 ++++
 rtl/reg_snapshot_ctrl.sv | 148 ++++++++++++++
 tb/tb_reg_snapshot_ctrl.sv | 298 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/mips_core_pkg.sv
// Shared core types for the register-file snapshot path.
// SNAP_TIMEOUT_CYCLES bounds the restore handshake when SNAP_CTRL_TIMEOUT_EN is defined.
package mips_core_pkg;

   localparam int DATA_WIDTH          = 32;
   localparam int SNAP_TIMEOUT_CYCLES = 16;

   typedef logic [31:0][DATA_WIDTH-1:0] snap_regs_t;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      RESTORE = 2'd1,
      WAIT    = 2'd2,
      ACK     = 2'd3
   } snap_state_t;

endpackage

// File: rtl/reg_snapshot_ctrl_if.sv
// Front-end side of the snapshot controller: checkpoint request, branch resolve, flow control.
// master = decode/branch-resolve logic, slave = reg_snapshot_ctrl.
interface reg_snapshot_ctrl_if #(
   parameter int TAG_WIDTH = 2
);
   logic                 take_snapshot;
   logic [TAG_WIDTH-1:0] snap_tag;
   logic                 resolve_valid;
   logic [TAG_WIDTH-1:0] resolve_tag;
   logic                 resolve_mispredict;
   logic                 full;
   logic                 stall;

   modport master (
      output take_snapshot, resolve_valid, resolve_tag, resolve_mispredict,
      input  snap_tag, full, stall
   );

   modport slave (
      input  take_snapshot, resolve_valid, resolve_tag, resolve_mispredict,
      output snap_tag, full, stall
   );
endinterface

// File: rtl/snapshot_store.sv
// DEPTH-slot register-array store: one write port with write-back merge, one combinational read.
// Write takes effect at the clock edge; read reflects the slot contents immediately.
module snapshot_store
   import mips_core_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  wr_en,
   input  logic [TAG_WIDTH-1:0]  wr_idx,
   input  snap_regs_t            wr_regs,
   input  logic                  wb_en,
   input  logic [4:0]            wb_addr,
   input  logic [DATA_WIDTH-1:0] wb_data,
   input  logic [TAG_WIDTH-1:0]  rd_idx,
   output snap_regs_t            rd_regs
);

   snap_regs_t slots [DEPTH];
   snap_regs_t wr_merged;

   // A same-cycle write-back has not reached regs_in yet; r0 stays hard-wired zero.
   always_comb begin
      wr_merged = wr_regs;
      if (wb_en && (wb_addr != 5'd0)) begin
         wr_merged[wb_addr] = wb_data;
      end
   end

   // Cleared on reset so the restore bus idles at zero rather than X.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            slots[i] <= '0;
         end
      end else if (wr_en) begin
         slots[wr_idx] <= wr_merged;
      end
   end

   assign rd_regs = slots[rd_idx];

endmodule

// File: rtl/reg_snapshot_ctrl.sv
// Branch checkpoint controller: circular snapshot buffer, in-order retire, mispredict restore (>=3 cycles to ack).
// Stalls the front end while full or recovering; SNAP_CTRL_TIMEOUT_EN bounds the wait for reg_file done.
module reg_snapshot_ctrl
   import mips_core_pkg::*;
#(
   parameter int DEPTH     = 4,
   parameter int TAG_WIDTH = $clog2(DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst_n,
   reg_snapshot_ctrl_if.slave    fe,
   input  snap_regs_t            regs_in,
   input  logic                  wb_uses_rw,
   input  logic [4:0]            wb_rw_addr,
   input  logic [DATA_WIDTH-1:0] wb_rw_data,
   output logic                  recover_snapshot,
   output snap_regs_t            regs_snapshot,
   input  logic                  done,
   output logic                  recovery_done_ack,
   output logic                  timeout_err
);

   localparam int               CNT_W      = TAG_WIDTH + 1;
   localparam logic [CNT_W-1:0] CNT_FULL   = CNT_W'(DEPTH);
   localparam logic [1:0]       ST_IDLE    = IDLE;
   localparam logic [1:0]       ST_RESTORE = RESTORE;
   localparam logic [1:0]       ST_WAIT    = WAIT;
   localparam logic [1:0]       ST_ACK     = ACK;

   logic [1:0]           state;
   logic [TAG_WIDTH-1:0] head;
   logic [TAG_WIDTH-1:0] tail;
   logic [TAG_WIDTH-1:0] rtag;
   logic [TAG_WIDTH-1:0] rd_idx;
   logic [TAG_WIDTH-1:0] mp_off;
   logic [CNT_W-1:0]     count;
   logic                 is_idle;
   logic                 full_i;
   logic                 mp_req;
   logic                 mp_accept;
   logic                 cap;
   logic                 cr;
   logic                 wait_expired;

   assign is_idle = (state == ST_IDLE);
   assign full_i  = (count == CNT_FULL);
   assign mp_req  = fe.resolve_valid && fe.resolve_mispredict;

   // Distance from the oldest live slot; a tag is in flight only if it lies inside the occupied window.
   assign mp_off    = fe.resolve_tag - head;
   assign mp_accept = is_idle && mp_req && ({1'b0, mp_off} < count);
   assign cap       = is_idle && fe.take_snapshot && !full_i && !mp_req;
   assign cr        = is_idle && fe.resolve_valid && !fe.resolve_mispredict && (count != '0);

   assign fe.snap_tag        = tail;
   assign fe.full            = full_i;
   assign fe.stall           = full_i || !is_idle;
   assign recover_snapshot   = (state == ST_RESTORE);
   assign recovery_done_ack  = (state == ST_ACK);
   assign rd_idx             = is_idle ? head : rtag;

   snapshot_store #(
      .DEPTH     (DEPTH),
      .TAG_WIDTH (TAG_WIDTH)
   ) u_store (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (cap),
      .wr_idx  (tail),
      .wr_regs (regs_in),
      .wb_en   (wb_uses_rw),
      .wb_addr (wb_rw_addr),
      .wb_data (wb_rw_data),
      .rd_idx  (rd_idx),
      .rd_regs (regs_snapshot)
   );

`ifdef SNAP_CTRL_TIMEOUT_EN
   localparam int TO_W = $clog2(SNAP_TIMEOUT_CYCLES) + 1;

   logic [TO_W-1:0] wait_cnt;
   logic            timeout_q;

   assign wait_expired = (wait_cnt == TO_W'(SNAP_TIMEOUT_CYCLES - 1));
   assign timeout_err  = timeout_q;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt  <= '0;
         timeout_q <= 1'b0;
      end else begin
         if (state == ST_WAIT) begin
            wait_cnt <= wait_cnt + TO_W'(1);
         end else begin
            wait_cnt <= '0;
         end
         if ((state == ST_WAIT) && !done && wait_expired) begin
            timeout_q <= 1'b1;
         end
      end
   end
`else
   assign wait_expired = 1'b0;
   assign timeout_err  = 1'b0;
`endif

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= ST_IDLE;
         head  <= '0;
         tail  <= '0;
         count <= '0;
         rtag  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (mp_accept) begin
                  // Squash the mispredicted slot and everything younger; it is still readable for the restore.
                  rtag  <= fe.resolve_tag;
                  tail  <= fe.resolve_tag;
                  count <= {1'b0, mp_off};
                  state <= ST_RESTORE;
               end else begin
                  if (cap) begin
                     tail <= tail + TAG_WIDTH'(1);
                  end
                  if (cr) begin
                     head <= head + TAG_WIDTH'(1);
                  end
                  if (cap && !cr) begin
                     count <= count + CNT_W'(1);
                  end else if (cr && !cap) begin
                     count <= count - CNT_W'(1);
                  end
               end
            end
            ST_RESTORE: state <= ST_WAIT;
            ST_WAIT: begin
               if (done || wait_expired) begin
                  state <= ST_ACK;
               end
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_snapshot_ctrl.sv
// Self-checking bench for reg_snapshot_ctrl: directed scenarios plus a randomized run against a queue model.
// Define SNAP_CTRL_TIMEOUT_EN for both bench and RTL to exercise the restore timeout.
module tb_reg_snapshot_ctrl;
   import mips_core_pkg::*;

   localparam int DEPTH = 4;
   localparam int TW    = 2;

   logic                  clk = 1'b0;
   logic                  rst_n = 1'b0;
   snap_regs_t            regs_in;
   logic                  wb_uses_rw;
   logic [4:0]            wb_rw_addr;
   logic [DATA_WIDTH-1:0] wb_rw_data;
   logic                  recover_snapshot;
   snap_regs_t            regs_snapshot;
   logic                  done;
   logic                  recovery_done_ack;
   logic                  timeout_err;

   reg_snapshot_ctrl_if #(.TAG_WIDTH(TW)) fe ();

   reg_snapshot_ctrl #(
      .DEPTH     (DEPTH),
      .TAG_WIDTH (TW)
   ) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fe                (fe),
      .regs_in           (regs_in),
      .wb_uses_rw        (wb_uses_rw),
      .wb_rw_addr        (wb_rw_addr),
      .wb_rw_data        (wb_rw_data),
      .recover_snapshot  (recover_snapshot),
      .regs_snapshot     (regs_snapshot),
      .done              (done),
      .recovery_done_ack (recovery_done_ack),
      .timeout_err       (timeout_err)
   );

   always #5 clk = ~clk;

   // Model: live snapshots oldest-first; tag of q[i] is (head_m + i) mod DEPTH.
   snap_regs_t q[$];
   int         head_m;
   int         checks;
   int         failures;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_regs(input string tag, input snap_regs_t obs, input snap_regs_t exp);
      int idx;
      idx = 0;
      for (int i = 31; i >= 0; i--) begin
         if (obs[i] !== exp[i]) idx = i;
      end
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s reg[%0d] observed=%h expected=%h", tag, idx, obs[idx], exp[idx]);
      end
   endtask

   function automatic snap_regs_t merge(input snap_regs_t r, input logic en, input logic [4:0] a,
                                        input logic [DATA_WIDTH-1:0] d);
      snap_regs_t m;
      m = r;
      if (en && a != 5'd0) m[a] = d;
      return m;
   endfunction

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic drive_quiet;
      fe.take_snapshot      = 1'b0;
      fe.resolve_valid      = 1'b0;
      fe.resolve_mispredict = 1'b0;
      fe.resolve_tag        = '0;
      wb_uses_rw            = 1'b0;
      done                  = 1'b0;
   endtask

   task automatic randomize_regs;
      for (int i = 0; i < 32; i++) regs_in[i] = $urandom();
      wb_uses_rw = 1'($urandom_range(0, 1));
      wb_rw_addr = 5'($urandom_range(0, 31));
      wb_rw_data = $urandom();
   endtask

   task automatic do_reset;
      rst_n = 1'b0;
      drive_quiet();
      tick();
      tick();
      rst_n  = 1'b1;
      head_m = 0;
      q.delete();
   endtask

   // One IDLE-state cycle: apply inputs, check outputs against the model, advance the model at the edge.
   task automatic idle_step(input logic take, input logic rv, input logic mp, input logic [TW-1:0] rt,
                            output logic mp_acc, output snap_regs_t mp_regs);
      logic exp_full;
      logic cap;
      logic cr;
      int   off;
      fe.take_snapshot      = take;
      fe.resolve_valid      = rv;
      fe.resolve_mispredict = mp;
      fe.resolve_tag        = rt;
      done                  = 1'b0;
      #1;
      exp_full = (q.size() == DEPTH);
      check("full", fe.full, exp_full);
      check("stall_idle", fe.stall, exp_full);
      check("recover_idle", recover_snapshot, 0);
      check("ack_idle", recovery_done_ack, 0);
      if (take && !exp_full) check("snap_tag", fe.snap_tag, (head_m + q.size()) % DEPTH);
      if (q.size() > 0) check_regs("regs_head", regs_snapshot, q[0]);
      off     = (int'(rt) - head_m + DEPTH) % DEPTH;
      mp_acc  = rv && mp && (off < q.size());
      mp_regs = '0;
      cap     = take && !exp_full && !(rv && mp);
      cr      = rv && !mp && (q.size() > 0);
      if (mp_acc) begin
         mp_regs = q[off];
         while (q.size() > off) void'(q.pop_back());
      end else begin
         if (cap) q.push_back(merge(regs_in, wb_uses_rw, wb_rw_addr, wb_rw_data));
         if (cr) begin
            void'(q.pop_front());
            head_m = (head_m + 1) % DEPTH;
         end
      end
      tick();
      drive_quiet();
   endtask

   // Entered in RESTORE; front-end traffic is kept active throughout and must be ignored.
   task automatic recover(input snap_regs_t exp, input int dly);
      fe.take_snapshot      = 1'b1;
      fe.resolve_valid      = 1'b1;
      fe.resolve_mispredict = 1'($urandom_range(0, 1));
      fe.resolve_tag        = TW'($urandom_range(0, DEPTH - 1));
      done                  = 1'b0;
      #1;
      check("restore_pulse", recover_snapshot, 1);
      check_regs("restore_regs", regs_snapshot, exp);
      check("restore_stall", fe.stall, 1);
      check("restore_ack", recovery_done_ack, 0);
      tick();
      for (int k = 0; k <= dly; k++) begin
         done = (k == dly);
         #1;
         check("wait_pulse", recover_snapshot, 0);
         check_regs("wait_regs", regs_snapshot, exp);
         check("wait_stall", fe.stall, 1);
         check("wait_ack", recovery_done_ack, 0);
         tick();
      end
      done = 1'b0;
      #1;
      check("ack_pulse", recovery_done_ack, 1);
      check("ack_stall", fe.stall, 1);
      check_regs("ack_regs", regs_snapshot, exp);
      drive_quiet();
      tick();
      check("ack_single", recovery_done_ack, 0);
   endtask

   initial begin
      logic       acc;
      snap_regs_t exp_regs;
      snap_regs_t zero_regs;
      checks     = 0;
      failures   = 0;
      zero_regs  = '0;
      regs_in    = '0;
      wb_rw_addr = '0;
      wb_rw_data = '0;
      do_reset();

      // Reset state
      check("rst_snap_tag", fe.snap_tag, 0);
      check("rst_full", fe.full, 0);
      check("rst_stall", fe.stall, 0);
      check("rst_recover", recover_snapshot, 0);
      check("rst_ack", recovery_done_ack, 0);
      check("rst_timeout", timeout_err, 0);
      check_regs("rst_regs", regs_snapshot, zero_regs);

      // Capture with write-back merge of r5
      regs_in    = '0;
      wb_uses_rw = 1'b1;
      wb_rw_addr = 5'd5;
      wb_rw_data = 32'hDEAD;
      idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);
      #1;
      check("merge_r5", regs_snapshot[5], 32'hDEAD);

      // Fill to DEPTH, then one dropped request
      for (int i = 0; i < DEPTH; i++) begin
         randomize_regs();
         idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);
      end
      check("fill_full", fe.full, 1);

      // In-order correct resolves; second shares a cycle with a capture that wraps to tag 0
      idle_step(1'b0, 1'b1, 1'b0, 2'd0, acc, exp_regs);
      randomize_regs();
      idle_step(1'b1, 1'b1, 1'b0, 2'd1, acc, exp_regs);
      check("wrap_head", head_m, 2);

      // Mispredict of tag 1 with tags 0..2 live
      do_reset();
      for (int i = 0; i < 3; i++) begin
         randomize_regs();
         idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);
      end
      idle_step(1'b0, 1'b1, 1'b1, 2'd1, acc, exp_regs);
      check("mp_accept", acc, 1);
      recover(exp_regs, 0);
      randomize_regs();
      idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);

      // Simultaneous mispredict and capture: the capture is dropped
      randomize_regs();
      idle_step(1'b1, 1'b1, 1'b1, 2'd1, acc, exp_regs);
      check("mp_take_accept", acc, 1);
      recover(exp_regs, 2);

      // Reset while waiting for done
      idle_step(1'b0, 1'b1, 1'b1, 2'd0, acc, exp_regs);
      check("mp_rst_accept", acc, 1);
      tick();
      rst_n = 1'b0;
      tick();
      check("rst_wait_ack", recovery_done_ack, 0);
      check("rst_wait_stall", fe.stall, 0);
      check("rst_wait_recover", recover_snapshot, 0);
      rst_n  = 1'b1;
      head_m = 0;
      q.delete();
      randomize_regs();
      idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);

      // Randomized traffic
      for (int n = 0; n < 400; n++) begin
         int   sel;
         logic take;
         randomize_regs();
         take = 1'($urandom_range(0, 1));
         sel  = $urandom_range(0, 9);
         if (sel < 5) begin
            idle_step(take, 1'b0, 1'b0, '0, acc, exp_regs);
         end else if (sel < 8) begin
            idle_step(take, 1'b1, 1'b0, TW'(head_m), acc, exp_regs);
         end else begin
            idle_step(take, 1'b1, 1'b1, TW'($urandom_range(0, DEPTH - 1)), acc, exp_regs);
         end
         if (acc) recover(exp_regs, $urandom_range(0, 3));
      end

`ifdef SNAP_CTRL_TIMEOUT_EN
      do_reset();
      randomize_regs();
      idle_step(1'b1, 1'b0, 1'b0, '0, acc, exp_regs);
      idle_step(1'b0, 1'b1, 1'b1, 2'd0, acc, exp_regs);
      check("to_accept", acc, 1);
      tick();
      for (int k = 0; k < SNAP_TIMEOUT_CYCLES; k++) begin
         check("to_wait_ack", recovery_done_ack, 0);
         check("to_wait_err", timeout_err, 0);
         tick();
      end
      check("to_ack", recovery_done_ack, 1);
      check("to_err", timeout_err, 1);
      tick();
      check("to_err_sticky", timeout_err, 1);
      check("to_ack_single", recovery_done_ack, 0);
`else
      check("timeout_tied", timeout_err, 0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
